// File: rtl/ecc_enc_dec_apb_core.sv
// APB-programmable SECDED (extended Hamming) encoder/decoder with run-time codeword width
// (8/16/32) and encode, decode and full-channel (encode, add noise, decode) modes.
module ecc_enc_dec_apb_core #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  localparam int unsigned CW    = 32;
  localparam int unsigned KMAX  = 26;
  localparam logic [1:0]  WMAX  = (DATA_WIDTH >= 32) ? 2'd2 : (DATA_WIDTH >= 16) ? 2'd1 : 2'd0;
  localparam logic [1:0]  M_ENC = 2'd0;
  localparam logic [1:0]  M_DEC = 2'd1;
  localparam logic [1:0]  M_FUL = 2'd2;

  typedef enum logic [1:0] {IDLE, CALC, CHAN, DONE} state_t;

  // Hamming position of data bit i: i-th integer >= 3 that is not a power of two
  function automatic logic [4:0] hpos(input int unsigned i);
    int unsigned cnt;
    logic [4:0]  r;
    cnt = 0;
    r   = '0;
    for (int unsigned p = 3; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == i) r = 5'(p);
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic int unsigned n_of(input logic [1:0] w);
    return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
  endfunction

  function automatic int unsigned m_of(input logic [1:0] w);
    return (w == 2'd0) ? 3 : (w == 2'd1) ? 4 : 5;
  endfunction

  function automatic logic [CW-1:0] lomask(input int unsigned b);
    return (b >= CW) ? '1 : ((CW'(1) << b) - CW'(1));
  endfunction

  // Check bit j is the XOR of data bits whose position has bit j set
  function automatic logic [4:0] checks(input logic [CW-1:0] d, input int unsigned k);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < KMAX; i++)
      if (i < k && d[i]) c = c ^ hpos(i);
    return c;
  endfunction

  state_t               state_q;
  logic [1:0]           ctrl_q, width_reg_q, mode_q, wcode_q;
  logic [AMBA_WORD-1:0] din_reg_q, noise_reg_q, rd_mux;
  logic [CW-1:0]        din_q, noise_q, cw_q;
  logic                 wr_en, start;
  logic [1:0]           wclamp;
  int unsigned          n_w, m_w, k_w;
  logic [CW-1:0]        enc_cw, enc_dm;
  logic [CW-1:0]        dec_src, dec_r, dec_dm, dec_data;
  logic [4:0]           dec_s;
  logic                 dec_e;
  logic [1:0]           dec_err;
  logic                 unused_paddr;

  assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
  assign wr_en        = PSEL && PENABLE && PWRITE;
  assign start        = wr_en && (PADDR[3:2] == 2'd0) && (PWDATA[1:0] != 2'd3);

  always_comb begin
    wclamp = width_reg_q[1] ? 2'd2 : width_reg_q;
    if (wclamp > WMAX) wclamp = WMAX;
    n_w = n_of(wcode_q);
    m_w = m_of(wcode_q);
    k_w = n_w - m_w - 1;
  end

  always_comb begin
    case (PADDR[3:2])
      2'd0:    rd_mux = AMBA_WORD'(ctrl_q);
      2'd1:    rd_mux = din_reg_q;
      2'd2:    rd_mux = AMBA_WORD'(width_reg_q);
      default: rd_mux = noise_reg_q;
    endcase
  end

  // Encoder: data, then checks, then overall parity at the top bit
  always_comb begin
    enc_dm = din_q & lomask(k_w);
    enc_cw = enc_dm | (CW'(checks(enc_dm, k_w)) << k_w);
    enc_cw = enc_cw | (CW'(^enc_cw) << (n_w - 1));
  end

  // Decoder: received word is DATA_IN (decode) or the noisy codeword (full channel)
  always_comb begin
    dec_src  = (state_q == CHAN) ? cw_q : din_q;
    dec_r    = dec_src & lomask(n_w);
    dec_dm   = dec_r & lomask(k_w);
    dec_s    = checks(dec_dm, k_w) ^ (5'(dec_r >> k_w) & 5'(lomask(m_w)));
    dec_e    = ^dec_r;
    dec_data = dec_dm;
    dec_err  = 2'd0;
    if (dec_e) begin
      if (dec_s == 5'd0 || (dec_s & (dec_s - 5'd1)) == 5'd0) begin
        dec_err = 2'd1;
      end else if (32'(dec_s) >= n_w) begin
        dec_err = 2'd2;
      end else begin
        dec_err = 2'd1;
        for (int unsigned i = 0; i < KMAX; i++)
          if (i < k_w && hpos(i) == dec_s) dec_data[i] = ~dec_dm[i];
      end
    end else if (dec_s != 5'd0) begin
      dec_err = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ctrl_q         <= '0;
      width_reg_q    <= '0;
      din_reg_q      <= '0;
      noise_reg_q    <= '0;
      mode_q         <= '0;
      wcode_q        <= '0;
      din_q          <= '0;
      noise_q        <= '0;
      cw_q           <= '0;
      PRDATA         <= '0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
    end else begin
      operation_done <= 1'b0;
      if (PSEL && !PENABLE && !PWRITE) PRDATA <= rd_mux;
      if (wr_en) begin
        case (PADDR[3:2])
          2'd0:    ctrl_q      <= PWDATA[1:0];
          2'd1:    din_reg_q   <= PWDATA;
          2'd2:    width_reg_q <= PWDATA[1:0];
          default: noise_reg_q <= PWDATA;
        endcase
      end
      case (state_q)
        IDLE: if (start) begin
          mode_q  <= PWDATA[1:0];
          wcode_q <= wclamp;
          din_q   <= CW'(din_reg_q);
          noise_q <= CW'(noise_reg_q);
          state_q <= CALC;
        end
        CALC: if (mode_q == M_FUL) begin
          cw_q    <= enc_cw ^ (noise_q & lomask(n_w));
          state_q <= CHAN;
        end else begin
          data_out       <= (mode_q == M_ENC) ? DATA_WIDTH'(enc_cw) : DATA_WIDTH'(dec_data);
          num_of_errors  <= (mode_q == M_DEC) ? dec_err : 2'd0;
          operation_done <= 1'b1;
          state_q        <= DONE;
        end
        CHAN: begin
          data_out       <= DATA_WIDTH'(dec_data);
          num_of_errors  <= dec_err;
          operation_done <= 1'b1;
          state_q        <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_enc_dec_apb_core.sv
// Randomised scoreboard bench for ecc_enc_dec_apb_core: stimulus pushes expected results,
// a monitor pops and compares on each operation_done pulse.
module tb_ecc_enc_dec_apb_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] PADDR;
  logic [31:0] PWDATA, PRDATA, data_out;
  logic        PENABLE, PSEL, PWRITE, operation_done;
  logic [1:0]  num_of_errors;

  ecc_enc_dec_apb_core #(.DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  errs;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model
  function automatic int nbits(input int w);
    return (w == 0) ? 8 : (w == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] d, input int w);
    int          n, m, k;
    int unsigned h[$];
    logic [31:0] cw;
    logic        par;
    n = nbits(w);
    m = $clog2(n);
    k = n - m - 1;
    for (int unsigned p = 3; h.size() < k; p++)
      if ($countones(p) != 1) h.push_back(p);
    cw = '0;
    for (int i = 0; i < k; i++) cw[i] = d[i];
    for (int j = 0; j < m; j++) begin
      par = 1'b0;
      for (int i = 0; i < k; i++)
        if (d[i] && ((h[i] >> j) & 1) == 1) par = ~par;
      cw[k+j] = par;
    end
    cw[n-1] = ^cw;
    return cw;
  endfunction

  // Nearest-codeword decode: valid word, else any single flip landing on a valid word
  function automatic exp_t m_dec(input logic [31:0] rin, input int w);
    exp_t        res;
    int          n, k;
    logic [31:0] nm, km, r, t;
    n  = nbits(w);
    k  = n - $clog2(n) - 1;
    nm = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    km = (32'd1 << k) - 32'd1;
    r  = rin & nm;
    res.due = 0;
    if (m_enc(r & km, w) == r) begin
      res.errs = 2'd0;
      res.data = r & km;
    end else begin
      res.errs = 2'd2;
      res.data = r & km;
      for (int b = 0; b < n; b++) begin
        t = r ^ (32'd1 << b);
        if (m_enc(t & km, w) == t) begin
          res.errs = 2'd1;
          res.data = t & km;
        end
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && operation_done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got operation_done=1 at cycle %0d expected 0", cyc);
      end else begin
        mon_x = sb.pop_front();
        chk("data_out", data_out, mon_x.data);
        chk("num_of_errors", 32'(num_of_errors), 32'(mon_x.errs));
        chk("done_cycle", cyc, mon_x.due);
      end
    end
  end

  task automatic apb_write(input logic [19:0] addr, input logic [31:0] data, output int unsigned t);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [19:0] addr, output logic [31:0] data);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1'b1;
    data = PRDATA;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic start(input int mode, input logic [31:0] d, input logic [1:0] e);
    int unsigned t;
    exp_t x;
    apb_write(20'h0, 32'(mode), t);
    x.data = d;
    x.errs = e;
    x.due  = t + ((mode == 2) ? 3 : 2);
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no operation_done after %0d cycles expected %0d pulses", i, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input int mode, input int w, input logic [31:0] din, input logic [31:0] noise);
    int unsigned t;
    exp_t e;
    apb_write(20'h4, din, t);
    if (mode == 2) apb_write(20'hC, noise, t);
    if (mode == 0) begin
      e.data = m_enc(din, w);
      e.errs = 2'd0;
    end else if (mode == 1) begin
      e = m_dec(din, w);
    end else begin
      e = m_dec(m_enc(din, w) ^ noise, w);
    end
    start(mode, e.data, e.errs);
    wait_idle();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, garb;
    int unsigned t;
    int          n;
    rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_errors", 32'(num_of_errors), 32'h0);
    chk("rst_done", 32'(operation_done), 32'h0);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      apb_read(20'(a * 4), rd);
      chk("rst_reg_read", rd, 32'h0);
    end

    // Directed width-8 vectors
    apb_write(20'h8, 32'h0, t);
    apb_write(20'h4, 32'h0B, t);
    start(0, 32'h1B, 2'd0); wait_idle();
    apb_write(20'h4, 32'h1F, t);
    start(1, 32'hB, 2'd1); wait_idle();
    apb_write(20'h4, 32'h18, t);
    start(1, 32'h8, 2'd2); wait_idle();
    apb_write(20'h4, 32'h0B, t);
    apb_write(20'hC, 32'h80, t);
    start(2, 32'hB, 2'd1); wait_idle();
    apb_write(20'hC, 32'h0, t);
    start(2, 32'hB, 2'd0); wait_idle();

    // Register readback
    apb_write(20'h4, 32'hDEAD_BEEF, t);
    apb_write(20'hC, 32'h1234_5678, t);
    apb_write(20'h8, 32'h3, t);
    apb_read(20'h4, rd); chk("rd_data_in", rd, 32'hDEAD_BEEF);
    apb_read(20'hC, rd); chk("rd_noise", rd, 32'h1234_5678);
    apb_read(20'h8, rd); chk("rd_width", rd, 32'h3);
    apb_read(20'h0, rd); chk("rd_ctrl", rd, 32'h2);

    // CTRL writes while busy or with reserved mode do not start
    apb_write(20'h8, 32'h0, t);
    apb_write(20'h4, 32'h0B, t);
    apb_write(20'hC, 32'h80, t);
    start(2, 32'hB, 2'd1);
    apb_write(20'h0, 32'h1, t);
    wait_idle();
    repeat (4) @(negedge clk);
    apb_read(20'h0, rd); chk("rd_ctrl_busy", rd, 32'h1);
    apb_write(20'h0, 32'h3, t);
    repeat (6) @(negedge clk);
    apb_read(20'h0, rd); chk("rd_ctrl_mode3", rd, 32'h3);

    // Width sweep: random data, all 1- and 2-bit noise patterns
    for (int w = 0; w < 4; w++) begin
      apb_write(20'h8, 32'(w), t);
      n = nbits(w);
      for (int r = 0; r < 3; r++) run_op(0, w, $urandom, 32'h0);
      for (int r = 0; r < 4; r++) run_op(1, w, $urandom, 32'h0);
      run_op(2, w, $urandom, 32'h0);
      for (int b = 0; b < n; b++) begin
        garb = (n == 32) ? 32'h0 : ($urandom << n);
        run_op(2, w, $urandom, (32'd1 << b) | garb);
      end
      if (w != 3)
        for (int a = 0; a < n; a++)
          for (int b = a + 1; b < n; b++)
            run_op(2, w, $urandom, (32'd1 << a) | (32'd1 << b));
    end

    // Reset during CALC and CHAN aborts the operation
    apb_write(20'h8, 32'h0, t);
    run_op(0, 0, 32'h0B, 32'h0);
    apb_write(20'h0, 32'h2, t);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_calc_data", data_out, 32'h0);
    chk("abort_calc_errors", 32'(num_of_errors), 32'h0);
    chk("abort_calc_done", 32'(operation_done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    run_op(1, 0, 32'h1F, 32'h0);
    apb_write(20'h4, 32'h0B, t);
    apb_write(20'hC, 32'h01, t);
    apb_write(20'h0, 32'h2, t);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_chan_data", data_out, 32'h0);
    chk("abort_chan_errors", 32'(num_of_errors), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    apb_read(20'h4, rd); chk("abort_reg_cleared", rd, 32'h0);
    run_op(2, 0, 32'h0B, 32'h01);
    run_op(2, 0, 32'h05, 32'h03);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
